// File: rtl/matrix_transpose_stream.sv
// matrix_transpose_stream
//   Streams in an NUM_MG x NUM_PE matrix one row per beat and streams it back
//   out transposed, one column per beat (valid/ready on both sides).
//
//   Build option: define TRANSPOSE_DBUF_EN for two ping-pong banks, so the
//   next matrix can fill while the previous one drains. Without it there is
//   a single bank and input stalls for the whole drain.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        synchronous reset, active low
//   in_valid   in_row holds a valid row
//   in_ready   a row is accepted this cycle when in_valid is also high
//   in_row     NUM_PE elements of DATA_WIDTH; element j = matrix[r][j]
//   out_valid  out_col holds a valid column
//   out_ready  consumer takes the column this cycle
//   out_col    NUM_MG elements of DATA_WIDTH; element i = matrix[i][c]
//   out_last   out_col is the final column of the current matrix
//   busy       a partial matrix is held or a column is still pending

// One output element lane: holds row i of every bank and registers
// element [rcol] of the bank being drained onto its slice of out_col.
module mts_lane #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_PE     = 8,
    parameter int NB         = 1,
    parameter int CW         = 3
) (
    input  logic                              clk,
    input  logic                              we,
    input  logic                              wbank,
    input  logic [NUM_PE-1:0][DATA_WIDTH-1:0] wrow,
    input  logic                              rbank,
    input  logic [CW-1:0]                     rcol,
    output logic [DATA_WIDTH-1:0]             elem_q
);
    // Storage is deliberately not reset; stale contents are never presented
    // because out_valid only rises once a full matrix has been written.
    logic [NB-1:0][NUM_PE-1:0][DATA_WIDTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (we) mem[wbank] <= wrow;
    end

    // Bypass: the row written this cycle may be the last row of the bank
    // that starts draining next cycle, so read it straight from the input.
    always_ff @(posedge clk) begin
        if (we && (wbank == rbank)) elem_q <= wrow[rcol];
        else                        elem_q <= mem[rbank][rcol];
    end
endmodule

module matrix_transpose_stream #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_PE     = 8,
    parameter int NUM_MG     = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_PE-1:0][DATA_WIDTH-1:0] in_row,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_MG-1:0][DATA_WIDTH-1:0] out_col,
    output logic                              out_last,
    output logic                              busy
);
    localparam int RW = (NUM_MG > 1) ? $clog2(NUM_MG) : 1;
    localparam int CW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
`ifdef TRANSPOSE_DBUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} bank_st_e;

    bank_st_e      st_q [NB];
    bank_st_e      st_d [NB];
    logic [RW-1:0] row_cnt, row_d;
    logic [CW-1:0] col_cnt, col_d;
    logic          fill_ptr, fill_ptr_d;
    logic          drain_ptr, drain_ptr_d;
    logic          acc, done, last_row, last_col;
    logic          out_valid_q, out_last_q;
    logic          busy_c;

    // The fill bank is in DRAIN only when every bank is draining.
    assign in_ready = (st_q[fill_ptr] == FILL);

    // Handshakes are gated by reset so nothing is stored or counted then.
    assign acc      = rst && in_valid && in_ready;
    assign done     = rst && out_valid && out_ready;
    assign last_row = acc  && (row_cnt == RW'(NUM_MG - 1));
    assign last_col = done && (col_cnt == CW'(NUM_PE - 1));

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            st_d[b] = st_q[b];
            // Fill and drain banks always differ when both events coincide.
            if (last_row && (fill_ptr == 1'(b)))  st_d[b] = DRAIN;
            if (last_col && (drain_ptr == 1'(b))) st_d[b] = FILL;
        end
        row_d = row_cnt;
        if (acc) row_d = last_row ? '0 : row_cnt + RW'(1);
        col_d = col_cnt;
        if (done) col_d = last_col ? '0 : col_cnt + CW'(1);
`ifdef TRANSPOSE_DBUF_EN
        fill_ptr_d  = fill_ptr ^ last_row;
        drain_ptr_d = drain_ptr ^ last_col;
`else
        fill_ptr_d  = 1'b0;
        drain_ptr_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int b = 0; b < NB; b++) st_q[b] <= FILL;
            row_cnt     <= '0;
            col_cnt     <= '0;
            fill_ptr    <= 1'b0;
            drain_ptr   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            st_q        <= st_d;
            row_cnt     <= row_d;
            col_cnt     <= col_d;
            fill_ptr    <= fill_ptr_d;
            drain_ptr   <= drain_ptr_d;
            // Output flags track what the lanes load this edge.
            out_valid_q <= (st_d[drain_ptr_d] == DRAIN);
            out_last_q  <= (st_d[drain_ptr_d] == DRAIN) && (col_d == CW'(NUM_PE - 1));
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

    always_comb begin
        busy_c = (row_cnt != '0);
        for (int b = 0; b < NB; b++)
            if (st_q[b] == DRAIN) busy_c = 1'b1;
    end
    assign busy = busy_c;

    // Lane i owns stored row i and output element i. Lanes reload every
    // cycle; while stalled the draining bank and column are unchanged, so
    // out_col holds steady.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MG; gi++) begin : g_lane
            mts_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .NUM_PE     (NUM_PE),
                .NB         (NB),
                .CW         (CW)
            ) u_lane (
                .clk    (clk),
                .we     (acc && (row_cnt == RW'(gi))),
                .wbank  (fill_ptr),
                .wrow   (in_row),
                .rbank  (drain_ptr_d),
                .rcol   (col_d),
                .elem_q (out_col[gi])
            );
        end
    endgenerate
endmodule

// File: doc/matrix_transpose_stream.md
MATRIX_TRANSPOSE_STREAM -- requirements
Module: matrix_transpose_stream

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, giving the element width in bits.
REQ-002 The block SHALL have parameter NUM_PE, default 8, giving the elements per input row and the number of output columns.
REQ-003 The block SHALL have parameter NUM_MG, default 8, giving the rows per matrix and the elements per output column.
REQ-004 clk  input  1  clock; one clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-low (0 = reset).
REQ-006 in_valid  input  1  in_row carries a valid row.
REQ-007 in_ready  output  1  block accepts a row this cycle.
REQ-008 in_row  input  [DATA_WIDTH-1:0] x NUM_PE  one row; element j is matrix[r][j].
REQ-009 out_valid  output  1  out_col carries a valid column.
REQ-010 out_ready  input  1  consumer accepts the column this cycle.
REQ-011 out_col  output  [DATA_WIDTH-1:0] x NUM_MG  one column; element i is matrix[i][c].
REQ-012 out_last  output  1  out_col is column NUM_PE-1 of the current matrix.
REQ-013 busy  output  1  at least one row accepted or column pending.

Function
REQ-014 An input beat SHALL be accepted when in_valid && in_ready; an output beat SHALL complete when out_valid && out_ready.
REQ-015 Accepted rows SHALL be written to storage row index r = 0..NUM_MG-1 in arrival order; the row counter SHALL wrap to 0 after NUM_MG-1.
REQ-016 Bank state machine per bank: FILL (in_ready=1, out_valid=0) -> DRAIN on acceptance of row NUM_MG-1; DRAIN -> FILL on completion of column NUM_PE-1.
REQ-017 In DRAIN, out_col SHALL present column c, c = 0..NUM_PE-1 in order, with element i = stored row i element c; the column counter SHALL wrap to 0 after NUM_PE-1.
REQ-018 out_valid SHALL assert the cycle after the last row is accepted (1-cycle latency) and SHALL stay high, with out_col/out_last stable, until out_ready.
REQ-019 The block SHALL ignore in_row while in_ready=0; rows offered then SHALL NOT be stored or counted.
REQ-020 out_col SHALL be registered from storage; it SHALL be don't-care while out_valid=0.
REQ-021 A matrix SHALL be output exactly once; no partial matrix SHALL be emitted.
REQ-022 Back-to-back: with out_ready held 1, the NUM_PE columns SHALL drain in NUM_PE consecutive cycles.
REQ-023 busy SHALL be 0 only when row counter = 0 and no bank is in DRAIN.

Reset
REQ-024 While rst=0 at a clock edge: all banks SHALL go to FILL, row and column counters SHALL go to 0, out_valid=0, out_last=0, busy=0, and in_ready=1 the cycle after.
REQ-025 Reset mid-fill or mid-drain SHALL discard all stored and pending data; storage contents SHALL NOT be cleared.

Configuration
REQ-026 Macro TRANSPOSE_DBUF_EN SHALL select double buffering.
REQ-027 Without TRANSPOSE_DBUF_EN: one bank; in_ready=0 throughout DRAIN; the next matrix SHALL start filling only the cycle after out_last completes.
REQ-028 With TRANSPOSE_DBUF_EN: two ping-pong banks; the fill pointer SHALL toggle on last-row acceptance and the drain pointer on last-column completion; in_ready=0 only when both banks are in DRAIN.
REQ-029 With TRANSPOSE_DBUF_EN, last-row acceptance and last-column completion in the same cycle SHALL both take effect, with no lost beat.
REQ-030 With TRANSPOSE_DBUF_EN, a filled second bank SHALL begin output the cycle after the first bank's last column completes.

Verification
REQ-031 Reset check: hold rst=0 for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, busy=0 after release; nothing stored.
REQ-032 Basic transpose (8x8, 64-bit): feed rows with element[r][j]=r*8+j, out_ready=1 -> out_valid the cycle after row 7; column c element i = i*8+c; out_last on c=7 only.
REQ-033 Backpressure: out_ready=0 for 5 cycles on column 3 -> out_col stays matrix[*][3] and out_valid stays 1; in_ready=0 without TRANSPOSE_DBUF_EN.
REQ-034 Gapped input: in_valid toggling 1,0,1,0 -> only accepted beats advance the row counter; output is identical to REQ-032.
REQ-035 DBUF streaming (TRANSPOSE_DBUF_EN): two matrices back-to-back (second matrix with r*8+j+100) with out_ready=1 -> 16 columns with no gap after first output; the second matrix is fully accepted while the first drains.
REQ-036 Mid-drain reset: rst=0 after column 2 -> out_valid=0 next cycle; a new matrix afterwards outputs correctly from column 0.
